// File: rtl/gte_flag_writeback.sv
// GTE result writeback stage: stores clamped results into the MAC/IR/SXY/SZ/RGB registers
// and FIFOs, and accumulates the sticky FLAG register over one command.
module gte_flag_writeback (
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_cmdStart,
    input  logic        i_cmdEnd,
    input  logic        i_wrEn,
    input  logic [3:0]  i_wrSel,
    input  logic        i_AxPos,
    input  logic        i_AxNeg,
    input  logic        i_FPos,
    input  logic        i_FNeg,
    input  logic        i_G,
    input  logic        i_H,
    input  logic        i_B,
    input  logic        i_C,
    input  logic        i_D,
    input  logic        i_divOvf,
    input  logic [31:0] i_OutA,
    input  logic [15:0] i_OutB,
    input  logic [7:0]  i_OutC,
    input  logic [15:0] i_OutD,
    input  logic [10:0] i_OutG,
    input  logic [12:0] i_OutH,
    input  logic        i_cpuWr,
    input  logic [4:0]  i_cpuAddr,
    input  logic [31:0] i_cpuData,
    input  logic [7:0]  i_code,
    output logic [31:0] o_flag,
    output logic [31:0] o_mac0,
    output logic [31:0] o_mac1,
    output logic [31:0] o_mac2,
    output logic [31:0] o_mac3,
    output logic [15:0] o_ir0,
    output logic [15:0] o_ir1,
    output logic [15:0] o_ir2,
    output logic [15:0] o_ir3,
    output logic [31:0] o_sxy0,
    output logic [31:0] o_sxy1,
    output logic [31:0] o_sxy2,
    output logic [15:0] o_sz0,
    output logic [15:0] o_sz1,
    output logic [15:0] o_sz2,
    output logic [15:0] o_sz3,
    output logic [31:0] o_rgb0,
    output logic [31:0] o_rgb1,
    output logic [31:0] o_rgb2,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  stateQ, stateD;
    logic [30:12] flagQ, flagD;
    logic [30:12] setMask;
    logic [31:0] macQ [4];
    logic [31:0] macD [4];
    logic [15:0] irQ [4];
    logic [15:0] irD [4];
    logic [31:0] sxyQ [3];
    logic [31:0] sxyD [3];
    logic [15:0] szQ [4];
    logic [15:0] szD [4];
    logic [31:0] rgbQ [3];
    logic [31:0] rgbD [3];
    logic [15:0] sxStageQ, sxStageD;
    logic [7:0]  rStageQ, rStageD;
    logic [7:0]  gStageQ, gStageD;

    logic        resWr, cpuWr;
    logic        pushSxy;
    logic [31:0] pushSxyVal;
    logic [15:0] sxyExt;

    // cmdStart preempts both a same-cycle result write and a CPU write
    assign resWr  = i_wrEn && (stateQ != StIdle) && !i_cmdStart;
    assign cpuWr  = i_cpuWr && (stateQ != StRun) && !i_cmdStart;
    assign sxyExt = {{5{i_OutG[10]}}, i_OutG};

    always_comb begin
        stateD     = stateQ;
        flagD      = flagQ;
        setMask    = '0;
        macD       = macQ;
        irD        = irQ;
        sxyD       = sxyQ;
        szD        = szQ;
        rgbD       = rgbQ;
        sxStageD   = sxStageQ;
        rStageD    = rStageQ;
        gStageD    = gStageQ;
        pushSxy    = 1'b0;
        pushSxyVal = '0;

        if (i_cmdStart) begin
            stateD   = StRun;
            flagD    = '0;
            sxStageD = '0;
            rStageD  = '0;
            gStageD  = '0;
        end else begin
            case (stateQ)
                StRun:   if (i_cmdEnd) stateD = StDone;
                StDone:  stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end

        if (resWr) begin
            case (i_wrSel)
                4'd0: begin
                    macD[0]     = i_OutA;
                    setMask[16] = i_FPos;
                    setMask[15] = i_FNeg;
                end
                4'd1: begin
                    macD[1]     = i_OutA;
                    setMask[30] = i_AxPos;
                    setMask[27] = i_AxNeg;
                end
                4'd2: begin
                    macD[2]     = i_OutA;
                    setMask[29] = i_AxPos;
                    setMask[26] = i_AxNeg;
                end
                4'd3: begin
                    macD[3]     = i_OutA;
                    setMask[28] = i_AxPos;
                    setMask[25] = i_AxNeg;
                end
                4'd4: begin
                    irD[0]      = {3'b000, i_OutH};
                    setMask[12] = i_H;
                end
                4'd5: begin
                    irD[1]      = i_OutB;
                    setMask[24] = i_B;
                end
                4'd6: begin
                    irD[2]      = i_OutB;
                    setMask[23] = i_B;
                end
                4'd7: begin
                    irD[3]      = i_OutB;
                    setMask[22] = i_B;
                end
                4'd8: begin
                    sxStageD    = sxyExt;
                    setMask[14] = i_G;
                end
                4'd9: begin
                    pushSxy     = 1'b1;
                    pushSxyVal  = {sxyExt, sxStageQ};
                    setMask[13] = i_G;
                end
                4'd10: begin
                    szD[0]      = szQ[1];
                    szD[1]      = szQ[2];
                    szD[2]      = szQ[3];
                    szD[3]      = i_OutD;
                    setMask[18] = i_D;
                    setMask[17] = i_divOvf;
                end
                4'd11: begin
                    rStageD     = i_OutC;
                    setMask[21] = i_C;
                end
                4'd12: begin
                    gStageD     = i_OutC;
                    setMask[20] = i_C;
                end
                4'd13: begin
                    rgbD[0]     = rgbQ[1];
                    rgbD[1]     = rgbQ[2];
                    rgbD[2]     = {i_code, i_OutC, gStageQ, rStageQ};
                    setMask[19] = i_C;
                end
                default: ;
            endcase
            flagD = flagD | setMask;
        end

        // Bank-relative register index is addr[1:0] for every multi-register group
        if (cpuWr) begin
            case (i_cpuAddr)
                5'd31:                      flagD = i_cpuData[30:12];
                5'd24, 5'd25, 5'd26, 5'd27: macD[i_cpuAddr[1:0]] = i_cpuData;
                5'd8:                       irD[0] = {3'b000, i_cpuData[12:0]};
                5'd9, 5'd10, 5'd11:         irD[i_cpuAddr[1:0]] = i_cpuData[15:0];
                5'd12, 5'd13, 5'd14:        sxyD[i_cpuAddr[1:0]] = i_cpuData;
                5'd15: begin
                    pushSxy    = 1'b1;
                    pushSxyVal = i_cpuData;
                end
                5'd16, 5'd17, 5'd18, 5'd19: szD[i_cpuAddr[1:0]] = i_cpuData[15:0];
                5'd20, 5'd21, 5'd22:        rgbD[i_cpuAddr[1:0]] = i_cpuData;
                default: ;
            endcase
        end

        if (pushSxy) begin
            sxyD[0] = sxyQ[1];
            sxyD[1] = sxyQ[2];
            sxyD[2] = pushSxyVal;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            stateQ   <= StIdle;
            flagQ    <= '0;
            sxStageQ <= '0;
            rStageQ  <= '0;
            gStageQ  <= '0;
            for (int i = 0; i < 4; i++) begin
                macQ[i] <= '0;
                irQ[i]  <= '0;
                szQ[i]  <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                sxyQ[i] <= '0;
                rgbQ[i] <= '0;
            end
        end else begin
            stateQ   <= stateD;
            flagQ    <= flagD;
            sxStageQ <= sxStageD;
            rStageQ  <= rStageD;
            gStageQ  <= gStageD;
            macQ     <= macD;
            irQ      <= irD;
            sxyQ     <= sxyD;
            szQ      <= szD;
            rgbQ     <= rgbD;
        end
    end

    // Bit 31 summarises the error flags; 22:19 are informational only
    assign o_flag = {(|flagQ[30:23]) | (|flagQ[18:13]), flagQ, 12'h000};
    assign o_busy = (stateQ == StRun);
    assign o_done = (stateQ == StDone);

    assign o_mac0 = macQ[0];
    assign o_mac1 = macQ[1];
    assign o_mac2 = macQ[2];
    assign o_mac3 = macQ[3];
    assign o_ir0  = irQ[0];
    assign o_ir1  = irQ[1];
    assign o_ir2  = irQ[2];
    assign o_ir3  = irQ[3];
    assign o_sxy0 = sxyQ[0];
    assign o_sxy1 = sxyQ[1];
    assign o_sxy2 = sxyQ[2];
    assign o_sz0  = szQ[0];
    assign o_sz1  = szQ[1];
    assign o_sz2  = szQ[2];
    assign o_sz3  = szQ[3];
    assign o_rgb0 = rgbQ[0];
    assign o_rgb1 = rgbQ[1];
    assign o_rgb2 = rgbQ[2];

endmodule

// File: tb/tb_gte_flag_writeback.sv
// Bench for gte_flag_writeback: directed scenarios plus random traffic checked every cycle
// against a register-level reference model.
module tb_gte_flag_writeback;

    logic        clk = 1'b0;
    logic        nRst, cmdStart, cmdEnd, wrEn, cpuWr;
    logic [3:0]  wrSel;
    logic        axPos, axNeg, fPos, fNeg, gF, hF, bF, cF, dF, divOvf;
    logic [31:0] outA, cpuData;
    logic [15:0] outB, outD;
    logic [7:0]  outC, code;
    logic [10:0] outG;
    logic [12:0] outH;
    logic [4:0]  cpuAddr;
    logic [31:0] flag, mac0, mac1, mac2, mac3, sxy0, sxy1, sxy2, rgb0, rgb1, rgb2;
    logic [15:0] ir0, ir1, ir2, ir3, sz0, sz1, sz2, sz3;
    logic        busy, done;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: 0 idle, 1 run, 2 done
    int          mState;
    logic [31:0] mFlag;
    logic [31:0] mMac [4];
    logic [31:0] mSxy [3];
    logic [31:0] mRgb [3];
    logic [15:0] mIr [4];
    logic [15:0] mSz [4];
    logic [15:0] mSx;
    logic [7:0]  mR, mG;

    gte_flag_writeback dut (
        .i_clk(clk), .i_nRst(nRst), .i_cmdStart(cmdStart), .i_cmdEnd(cmdEnd),
        .i_wrEn(wrEn), .i_wrSel(wrSel),
        .i_AxPos(axPos), .i_AxNeg(axNeg), .i_FPos(fPos), .i_FNeg(fNeg),
        .i_G(gF), .i_H(hF), .i_B(bF), .i_C(cF), .i_D(dF), .i_divOvf(divOvf),
        .i_OutA(outA), .i_OutB(outB), .i_OutC(outC), .i_OutD(outD),
        .i_OutG(outG), .i_OutH(outH),
        .i_cpuWr(cpuWr), .i_cpuAddr(cpuAddr), .i_cpuData(cpuData), .i_code(code),
        .o_flag(flag), .o_mac0(mac0), .o_mac1(mac1), .o_mac2(mac2), .o_mac3(mac3),
        .o_ir0(ir0), .o_ir1(ir1), .o_ir2(ir2), .o_ir3(ir3),
        .o_sxy0(sxy0), .o_sxy1(sxy1), .o_sxy2(sxy2),
        .o_sz0(sz0), .o_sz1(sz1), .o_sz2(sz2), .o_sz3(sz3),
        .o_rgb0(rgb0), .o_rgb1(rgb1), .o_rgb2(rgb2),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expFlag();
        logic [31:0] f;
        f = mFlag & 32'h7FFF_F000;
        f[31] = (f & 32'h7F87_E000) != 0;
        return f;
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    task automatic modelReset();
        mState = 0; mFlag = 0; mSx = 0; mR = 0; mG = 0;
        for (int i = 0; i < 4; i++) begin mMac[i] = 0; mIr[i] = 0; mSz[i] = 0; end
        for (int i = 0; i < 3; i++) begin mSxy[i] = 0; mRgb[i] = 0; end
    endtask

    task automatic pushSxy(input logic [31:0] v);
        mSxy[0] = mSxy[1]; mSxy[1] = mSxy[2]; mSxy[2] = v;
    endtask

    // Applies the inputs sampled at one rising edge to the model
    task automatic modelEdge();
        int sel, a;
        bit resOk, cpuOk;
        if (!nRst) begin
            modelReset();
            return;
        end
        resOk = wrEn && mState != 0 && !cmdStart;
        cpuOk = cpuWr && mState != 1 && !cmdStart;
        if (cmdStart) begin mFlag = 0; mSx = 0; mR = 0; mG = 0; end
        sel = int'(wrSel);
        if (resOk) begin
            if (sel <= 3) mMac[sel] = outA;
            if (sel == 0) begin if (fPos) mFlag[16] = 1; if (fNeg) mFlag[15] = 1; end
            if (sel >= 1 && sel <= 3) begin
                if (axPos) mFlag[31 - sel] = 1;
                if (axNeg) mFlag[28 - sel] = 1;
            end
            if (sel == 4) begin mIr[0] = {3'b0, outH}; if (hF) mFlag[12] = 1; end
            if (sel >= 5 && sel <= 7) begin mIr[sel - 4] = outB; if (bF) mFlag[29 - sel] = 1; end
            if (sel == 8) begin mSx = sext11(outG); if (gF) mFlag[14] = 1; end
            if (sel == 9) begin pushSxy({sext11(outG), mSx}); if (gF) mFlag[13] = 1; end
            if (sel == 10) begin
                for (int i = 0; i < 3; i++) mSz[i] = mSz[i + 1];
                mSz[3] = outD;
                if (dF) mFlag[18] = 1;
                if (divOvf) mFlag[17] = 1;
            end
            if (sel >= 11 && sel <= 13 && cF) mFlag[32 - sel] = 1;
            if (sel == 11) mR = outC;
            if (sel == 12) mG = outC;
            if (sel == 13) begin
                mRgb[0] = mRgb[1]; mRgb[1] = mRgb[2]; mRgb[2] = {code, outC, mG, mR};
            end
        end
        if (cpuOk) begin
            a = int'(cpuAddr);
            if (a == 31) mFlag = cpuData & 32'h7FFF_F000;
            else if (a >= 24 && a <= 27) mMac[a - 24] = cpuData;
            else if (a == 8) mIr[0] = {3'b0, cpuData[12:0]};
            else if (a >= 9 && a <= 11) mIr[a - 8] = cpuData[15:0];
            else if (a >= 12 && a <= 14) mSxy[a - 12] = cpuData;
            else if (a == 15) pushSxy(cpuData);
            else if (a >= 16 && a <= 19) mSz[a - 16] = cpuData[15:0];
            else if (a >= 20 && a <= 22) mRgb[a - 20] = cpuData;
        end
        if (cmdStart) mState = 1;
        else if (mState == 1 && cmdEnd) mState = 2;
        else if (mState == 2) mState = 0;
    endtask

    task automatic checkAll();
        checkEq("flag", flag, expFlag());
        checkEq("busy", {31'b0, busy}, {31'b0, mState == 1});
        checkEq("done", {31'b0, done}, {31'b0, mState == 2});
        checkEq("mac0", mac0, mMac[0]); checkEq("mac1", mac1, mMac[1]);
        checkEq("mac2", mac2, mMac[2]); checkEq("mac3", mac3, mMac[3]);
        checkEq("ir0", {16'b0, ir0}, {16'b0, mIr[0]}); checkEq("ir1", {16'b0, ir1}, {16'b0, mIr[1]});
        checkEq("ir2", {16'b0, ir2}, {16'b0, mIr[2]}); checkEq("ir3", {16'b0, ir3}, {16'b0, mIr[3]});
        checkEq("sxy0", sxy0, mSxy[0]); checkEq("sxy1", sxy1, mSxy[1]);
        checkEq("sxy2", sxy2, mSxy[2]);
        checkEq("sz0", {16'b0, sz0}, {16'b0, mSz[0]}); checkEq("sz1", {16'b0, sz1}, {16'b0, mSz[1]});
        checkEq("sz2", {16'b0, sz2}, {16'b0, mSz[2]}); checkEq("sz3", {16'b0, sz3}, {16'b0, mSz[3]});
        checkEq("rgb0", rgb0, mRgb[0]); checkEq("rgb1", rgb1, mRgb[1]);
        checkEq("rgb2", rgb2, mRgb[2]);
    endtask

    task automatic clearIn();
        nRst = 1; cmdStart = 0; cmdEnd = 0; wrEn = 0; cpuWr = 0; wrSel = 0;
        {axPos, axNeg, fPos, fNeg, gF, hF, bF, cF, dF, divOvf} = '0;
        outA = 0; outB = 0; outC = 0; outD = 0; outG = 0; outH = 0;
        cpuAddr = 0; cpuData = 0; code = 0;
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
        clearIn();
    endtask

    // fl = {AxPos, AxNeg, FPos, FNeg, G, H, B, C, D, divOvf}
    task automatic doWr(input logic [3:0] sel, input logic [31:0] v, input logic [9:0] fl);
        wrEn = 1; wrSel = sel;
        {axPos, axNeg, fPos, fNeg, gF, hF, bF, cF, dF, divOvf} = fl;
        outA = v; outB = v[15:0]; outC = v[7:0]; outD = v[15:0]; outG = v[10:0]; outH = v[12:0];
        tick();
    endtask

    task automatic doCpu(input logic [4:0] a, input logic [31:0] d);
        cpuWr = 1; cpuAddr = a; cpuData = d;
        tick();
    endtask

    task automatic doStart(); cmdStart = 1; tick(); endtask
    task automatic doEnd();   cmdEnd = 1; tick(); endtask

    initial begin
        clearIn();
        modelReset();
        nRst = 0;
        tick(); nRst = 0; tick();
        checkEq("reset_flag", flag, 32'h0);
        checkEq("reset_busy", {31'b0, busy}, 32'h0);

        // MAC1 positive overflow
        doStart();
        checkEq("busy_after_start", {31'b0, busy}, 32'h1);
        doWr(4'd1, 32'h7FFF_FFFF, 10'b1000000000);
        checkEq("mac1_sat", mac1, 32'h7FFF_FFFF);
        checkEq("flag_mac1", flag, 32'hC000_0000);
        doEnd();
        checkEq("done_pulse", {31'b0, done}, 32'h1);
        tick();
        checkEq("done_gone", {31'b0, done}, 32'h0);
        checkEq("busy_gone", {31'b0, busy}, 32'h0);

        // IR1 B flag (bit24, summarised), then R colour flag (bit21, not summarised)
        doStart();
        doWr(4'd5, 32'h0000_8000, 10'b0000001000);
        checkEq("flag_ir1", flag, 32'h8100_0000);
        doWr(4'd11, 32'h0000_0011, 10'b0000000100);
        checkEq("flag_r", flag, 32'h8120_0000);
        doWr(4'd12, 32'h0000_0022, 10'b0);
        code = 8'h2C;
        doWr(4'd13, 32'h0000_0033, 10'b0);
        checkEq("rgb2_push", rgb2, 32'h2C33_2211);

        // SX/SY FIFO
        doWr(4'd8, 32'h3FF, 10'b0); doWr(4'd9, 32'h400, 10'b0);
        doWr(4'd8, 32'h2, 10'b0);   doWr(4'd9, 32'h3, 10'b0);
        doWr(4'd8, 32'h4, 10'b0);   doWr(4'd9, 32'h5, 10'b0);
        checkEq("sxy0_neg", sxy0, 32'hFC00_03FF);
        checkEq("sxy1", sxy1, 32'h0003_0002);
        checkEq("sxy2", sxy2, 32'h0005_0004);
        doWr(4'd8, 32'h6, 10'b0);   doWr(4'd9, 32'h7, 10'b0);
        checkEq("sxy0_shift", sxy0, 32'h0003_0002);
        checkEq("sxy2_new", sxy2, 32'h0007_0006);
        doEnd(); tick();

        // SZ FIFO with D flag in a fresh command
        doStart();
        for (int i = 1; i <= 4; i++) doWr(4'd10, i, 10'b0);
        doWr(4'd10, 32'hFFFF, 10'b0000000010);
        checkEq("sz0", {16'b0, sz0}, 32'h2);
        checkEq("sz3", {16'b0, sz3}, 32'hFFFF);
        checkEq("flag_sz", flag, 32'h8004_0000);
        doEnd(); tick();

        // CPU writes: accepted in IDLE, dropped in RUN
        doCpu(5'd31, 32'hFFFF_FFFF);
        checkEq("cpu_flag_idle", flag, 32'hFFFF_F000);
        doStart();
        doCpu(5'd31, 32'hFFFF_FFFF);
        checkEq("cpu_flag_run", flag, 32'h0);
        doCpu(5'd24, 32'h1234_5678);
        checkEq("cpu_mac_run", mac0, 32'h0);
        doEnd(); tick();
        doCpu(5'd15, 32'h0020_0010);
        checkEq("cpu_sxyp2", sxy2, 32'h0020_0010);
        checkEq("cpu_sxyp1", sxy1, 32'h0007_0006);

        // Reset in the middle of a command
        doStart();
        doWr(4'd0, 32'hDEAD_BEEF, 10'b0001000000);
        checkEq("flag_fneg", flag, 32'h8000_8000);
        nRst = 0; cmdEnd = 1; tick();
        checkEq("rst_mid_flag", flag, 32'h0);
        checkEq("rst_mid_mac0", mac0, 32'h0);
        checkEq("rst_mid_done", {31'b0, done}, 32'h0);
        tick();
        checkEq("rst_no_done", {31'b0, done}, 32'h0);
        doStart(); doEnd();
        checkEq("post_rst_flag", flag, 32'h0);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            nRst     = ($urandom_range(0, 199) != 0);
            cmdStart = ($urandom_range(0, 24) == 0);
            cmdEnd   = ($urandom_range(0, 9) == 0);
            wrEn     = !cmdStart && ($urandom_range(0, 1) == 1);
            cpuWr    = !wrEn && ($urandom_range(0, 4) == 0);
            wrSel    = 4'($urandom_range(0, 15));
            {axPos, axNeg, fPos, fNeg, gF, hF, bF, cF, dF, divOvf} = 10'($urandom);
            if ($urandom_range(0, 3) != 0)
                {axPos, axNeg, fPos, fNeg, gF, hF, bF, cF, dF, divOvf} = '0;
            outA = $urandom; outB = 16'($urandom); outC = 8'($urandom);
            outD = 16'($urandom); outG = 11'($urandom); outH = 13'($urandom);
            cpuAddr = 5'($urandom); cpuData = $urandom; code = 8'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
